// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse and sticky flags.
// Optional count prescaler enabled by defining UDCNT_PRESCALE_EN.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
`ifdef UDCNT_PRESCALE_EN
    ,
    parameter int unsigned      PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    logic             step;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_next;
    logic             unf_next;

`ifdef UDCNT_PRESCALE_EN
    localparam int unsigned DW = $clog2(PRESCALE);

    logic [DW-1:0] div;
    logic          div_last;

    assign div_last = (div == DW'(PRESCALE - 1));
    assign step     = en & div_last;

    // Divider only runs while enabled; load restarts the step spacing.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            div <= '0;
        end else if (en) begin
            div <= div_last ? '0 : div + DW'(1);
        end
    end
`else
    assign step = en;
`endif

    always_comb begin
        q_next   = q;
        tc_next  = 1'b0;
        ovf_next = ovf & ~clr_flags;
        unf_next = unf & ~clr_flags;
        if (load) begin
            q_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (dir) begin
                // >= also recovers an out-of-range count as if at the boundary
                if (q >= MAX_VAL) begin
                    q_next   = SATURATE ? MAX_VAL : '0;
                    tc_next  = 1'b1;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    q_next   = SATURATE ? '0 : MAX_VAL;
                    tc_next  = 1'b1;
                    unf_next = 1'b1;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            q   <= q_next;
            tc  <= tc_next;
            ovf <= ovf_next;
            unf <= unf_next;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed scoreboard bench: instance 0 wraps, instance 1 saturates (WIDTH=4, MAX_VAL=9).
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic [1:0] rst = '0, en = '0, dir = '0, load = '0, clr = '0;
    logic [3:0] lv [2] = '{default: '0};
    logic [3:0] q  [2];
    logic [1:0] tc, ovf, unf;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         sel;
        logic [6:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    param_updown_counter #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)
`ifdef UDCNT_PRESCALE_EN
        , .PRESCALE(4)
`endif
    ) dut_wrap (
        .clk(clk), .rst(rst[0]), .en(en[0]), .dir(dir[0]), .load(load[0]),
        .load_val(lv[0]), .clr_flags(clr[0]),
        .q(q[0]), .tc(tc[0]), .ovf(ovf[0]), .unf(unf[0])
    );

    param_updown_counter #(
        .WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)
`ifdef UDCNT_PRESCALE_EN
        , .PRESCALE(4)
`endif
    ) dut_sat (
        .clk(clk), .rst(rst[1]), .en(en[1]), .dir(dir[1]), .load(load[1]),
        .load_val(lv[1]), .clr_flags(clr[1]),
        .q(q[1]), .tc(tc[1]), .ovf(ovf[1]), .unf(unf[1])
    );

    task automatic step(input int sel, input logic r, input logic l, input logic [3:0] v,
                        input logic e, input logic d, input logic c,
                        input logic [3:0] eq, input logic etc, input logic eo,
                        input logic eu, input string tag);
        exp_t       x;
        logic [6:0] obs;
        rst = '0; load = '0; en = '0; dir = '0; clr = '0;
        rst[sel] = r; load[sel] = l; en[sel] = e; dir[sel] = d; clr[sel] = c;
        lv[sel] = v;
        sb.push_back('{sel: sel, exp: {eq, etc, eo, eu}, tag: tag});
        @(posedge clk);
        #1;
        x   = sb.pop_front();
        obs = {q[x.sel], tc[x.sel], ovf[x.sel], unf[x.sel]};
        vectors++;
        assert (obs === x.exp) else begin
            miscompares++;
            $error("FAIL %s (dut %0d): observed q/tc/ovf/unf=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                   x.tag, x.sel, obs[6:3], obs[2], obs[1], obs[0],
                   x.exp[6:3], x.exp[2], x.exp[1], x.exp[0]);
        end
    endtask

    initial begin
`ifdef UDCNT_PRESCALE_EN
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 1, 1, 0, 4'(i / 4), 0, 0, 0, "prescale_up");
        end
        step(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, "prescale_partial");
        step(0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, "prescale_partial");
        step(0, 0, 1, 5, 0, 0, 0, 5, 0, 0, 0, "prescale_load");
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 1, 1, 0, (i == 4) ? 4'd6 : 4'd5, 0, 0, 0, "prescale_restart");
        end
`else
        // Wrapping instance
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, 0, 1, 1, 0, 4'(i), 0, 0, 0, "up_count");
        end
        step(0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, "up_wrap");
        step(0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, "after_wrap_1");
        step(0, 0, 0, 0, 1, 1, 0, 2, 0, 1, 0, "after_wrap_2");
        step(0, 0, 1, 9, 0, 0, 0, 9, 0, 1, 0, "load_max");
        step(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, "set_beats_clr");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "clr_no_event");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "load_zero");
        step(0, 0, 0, 0, 1, 0, 0, 9, 1, 0, 1, "down_wrap");
        step(0, 0, 0, 0, 1, 0, 0, 8, 0, 0, 1, "down_8");
        step(0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1, "down_7");
        step(0, 0, 0, 0, 1, 1, 0, 8, 0, 0, 1, "dir_toggle_up");
        step(0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 1, "dir_toggle_down");
        step(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 1, "hold");
        step(0, 0, 1, 14, 0, 0, 0, 9, 0, 0, 1, "load_clamp");
        step(0, 0, 1, 3, 1, 1, 1, 3, 0, 0, 0, "load_beats_en_clr");
        step(0, 0, 1, 9, 0, 0, 0, 9, 0, 0, 0, "load_max_again");
        step(0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, "wrap_again");
        step(0, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, "rst_beats_load");

        // Saturating instance
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_reset");
        step(1, 0, 1, 8, 0, 0, 0, 8, 0, 0, 0, "sat_load_8");
        step(1, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0, "sat_up_to_max");
        step(1, 0, 0, 0, 1, 1, 0, 9, 1, 1, 0, "sat_hold_max_1");
        step(1, 0, 0, 0, 1, 1, 0, 9, 1, 1, 0, "sat_hold_max_2");
        for (int i = 8; i >= 0; i--) begin
            step(1, 0, 0, 0, 1, 0, 0, 4'(i), 0, 1, 0, "sat_down");
        end
        step(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, "sat_hold_zero_1");
        step(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, "sat_hold_zero_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "sat_idle");
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised binary up/down counter, the next generation of the team's 4-bit up/down counter.
- Adds configurable width, a programmable modulus, a wrap or saturate mode, synchronous load and count enable.
- Adds a terminal-count pulse and sticky overflow/underflow flags.
- Used as a general event/position counter feeding display and timing logic.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..32.
MAX_VAL, 2**WIDTH-1, terminal value; legal range 1 <= MAX_VAL <= 2**WIDTH-1.
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous reset, active-high.
en  input  1  count enable.
dir  input  1  1 = count up, 0 = count down.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
clr_flags  input  1  clears the sticky flags.
q  output  WIDTH  registered count value.
tc  output  1  registered terminal-count pulse, one cycle wide.
ovf  output  1  sticky flag: an up-count hit the MAX_VAL boundary.
unf  output  1  sticky flag: a down-count hit the 0 boundary.

Behaviour:
- All state changes on the rising edge of clk. All outputs are registered, with no combinational path from inputs to outputs.
- Priority per edge: rst > load > en.
- Reset (rst=1): q=0, tc=0, ovf=0, unf=0. Reset overrides an in-progress count, load or clr_flags.
- Load (load=1, rst=0):
  - q <= load_val.
  - If load_val > MAX_VAL, q <= MAX_VAL (clamped).
  - tc=0 in the following cycle. en and dir are ignored that edge. Flags are unchanged, except that clr_flags is still honoured.
- Hold (en=0, load=0): q holds, tc=0.
- Up count (en=1, dir=1):
  - q < MAX_VAL: q <= q+1, tc=0.
  - q == MAX_VAL, SATURATE=0: q <= 0, tc=1, ovf <= 1.
  - q == MAX_VAL, SATURATE=1: q holds MAX_VAL, tc=1, ovf <= 1. tc re-pulses on every enabled up-count attempt while held at MAX_VAL.
- Down count (en=1, dir=0):
  - q > 0: q <= q-1, tc=0.
  - q == 0, SATURATE=0: q <= MAX_VAL, tc=1, unf <= 1.
  - q == 0, SATURATE=1: q holds 0, tc=1, unf <= 1.
- Out-of-range state: q is never > MAX_VAL in normal operation. If it is (e.g. X-recovery), the next enabled up-count behaves as the q == MAX_VAL case.
- Latency: q and tc reflect an event one cycle after the sampling edge. tc is high in the same cycle q shows the wrapped or held value.
- Sticky flags: clr_flags=1 clears ovf and unf. If a new boundary event occurs on the same edge, set wins over clear for that flag.
- Direction change: dir may toggle on any cycle with no penalty. Each edge uses the dir value sampled at that edge.
- Arithmetic: unsigned, modulo (MAX_VAL+1) in wrap mode. No internal width beyond WIDTH is required, except for the load comparison.

Optional Feature:
Macro: UDCNT_PRESCALE_EN
- Defined:
  - Adds parameter PRESCALE (default 4, legal range >= 2) and an internal divider counting 0..PRESCALE-1.
  - A count step occurs only on edges where en=1 and the divider equals PRESCALE-1.
  - The divider advances only while en=1, and resets to 0 on rst or load.
  - tc, ovf and unf fire only on actual steps.
- Not defined: no divider is instantiated; every enabled edge is a step. Ports are identical in both builds.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0; rst 1 cycle, then en=1, dir=1 for 12 cycles -> q = 1..9, 0, 1, 2; tc=1 only with q=0; ovf=1 from then on; unf=0.
2. Same configuration; load=1 with load_val=0, then dir=0, en=1 for 3 cycles -> q = 0, 9, 8, 7; tc=1 with q=9; unf=1.
3. SATURATE=1, MAX_VAL=9; load 8, then up-count 3 cycles -> q = 9, 9, 9; tc = 0, 1, 1; ovf=1. Then down-count to 0 and 2 more cycles -> q holds 0, tc=1 on each, unf=1.
4. load_val=14 with MAX_VAL=9 -> q=9. Same-edge load=1 and en=1, dir=1 with load_val=3 -> q=3, not 4. rst=1 asserted together with load=1 -> q=0, all flags 0.
5. ovf=1; on one edge drive clr_flags=1 together with a wrap from 9 -> ovf stays 1. On the next edge clr_flags=1 with no event -> ovf=0.
6. UDCNT_PRESCALE_EN defined, PRESCALE=4, en=1, dir=1 from q=0 for 12 cycles -> q increments on cycles 4, 8 and 12 only, reaching 3. A load mid-run restarts the 4-cycle spacing.
